// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEFAULT_DEPTH = 256;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IF   = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  // Misaligned or beyond the last RAM word.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// One-hot grant between fetch and load/store ports; only grants in ARB_IDLE.
// MEM_ARB_RR_EN selects round-robin instead of fixed data-over-fetch priority.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  arb_state_t state,
  input  logic       if_valid,
  input  logic       d_valid,
`ifdef MEM_ARB_RR_EN
  input  owner_t     rr_ptr,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = GRANT_NONE;
    if (state == ARB_IDLE) begin
`ifdef MEM_ARB_RR_EN
      // rr_ptr holds the last winner; the other port wins a tie.
      if (if_valid && d_valid)
        grant = (rr_ptr == OWN_D) ? GRANT_IF : GRANT_D;
      else if (d_valid)
        grant = GRANT_D;
      else if (if_valid)
        grant = GRANT_IF;
`else
      if (d_valid)
        grant = GRANT_D;
      else if (if_valid)
        grant = GRANT_IF;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 1-cycle-read RAM between fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: data over fetch).
//
// state      | meaning
// ARB_IDLE   | accepting one request, RAM driven combinationally on handshake
// ARB_ACCESS | returning read data / write ack to the latched owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [31:0]   if_addr,
  output logic          if_rsp_valid,
  output logic          if_rsp_err,
  output logic [31:0]   if_rdata,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic          d_we,
  input  logic [3:0]    d_wstrb,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_rsp_valid,
  output logic          d_rsp_err,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  arb_state_t  state, state_nxt;
  owner_t      owner, owner_nxt;
  logic        fault_q, fault_nxt;
  logic        store_q, store_nxt;
  logic [1:0]  grant;
  logic [31:0] sel_addr;
  logic        sel_fault;
  logic [31:0] rsp_rdata;
`ifdef MEM_ARB_RR_EN
  owner_t      rr_ptr, rr_ptr_nxt;
`endif

  mem_arb_select u_select (
    .state    (state),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
`ifdef MEM_ARB_RR_EN
    .rr_ptr   (rr_ptr),
`endif
    .grant    (grant)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ARB_IDLE;
      owner   <= OWN_IF;
      fault_q <= 1'b0;
      store_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_ptr  <= OWN_D;
`endif
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      fault_q <= fault_nxt;
      store_q <= store_nxt;
`ifdef MEM_ARB_RR_EN
      rr_ptr  <= rr_ptr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    fault_nxt    = fault_q;
    store_nxt    = store_q;
`ifdef MEM_ARB_RR_EN
    rr_ptr_nxt   = rr_ptr;
`endif
    sel_addr     = 32'h0;
    sel_fault    = 1'b0;
    rsp_rdata    = 32'h0;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_err   = 1'b0;
    if_rdata     = 32'h0;
    d_rsp_valid  = 1'b0;
    d_rsp_err    = 1'b0;
    d_rdata      = 32'h0;
    mem_en       = 1'b0;
    mem_we       = 4'h0;
    mem_addr     = '0;
    mem_wdata    = 32'h0;

    // Outputs stay quiet while reset is asserted, even with valids high.
    if (reset) begin
      case (state)
        ARB_IDLE: begin
          if_req_ready = grant[0];
          d_req_ready  = grant[1];
          if (grant != GRANT_NONE) begin
            sel_addr  = grant[1] ? d_addr : if_addr;
            sel_fault = addr_fault(sel_addr, DEPTH);
            owner_nxt = grant[1] ? OWN_D : OWN_IF;
            fault_nxt = sel_fault;
            store_nxt = grant[1] & d_we;
            state_nxt = ARB_ACCESS;
`ifdef MEM_ARB_RR_EN
            rr_ptr_nxt = grant[1] ? OWN_D : OWN_IF;
`endif
            if (!sel_fault) begin
              mem_en   = 1'b1;
              mem_addr = sel_addr[AW+1:2];
              if (grant[1] && d_we) begin
                mem_we    = d_wstrb;
                mem_wdata = d_wdata;
              end
            end
          end
        end
        ARB_ACCESS: begin
          state_nxt = ARB_IDLE;
          rsp_rdata = (fault_q || store_q) ? 32'h0 : mem_rdata;
          if (owner == OWN_D) begin
            d_rsp_valid = 1'b1;
            d_rsp_err   = fault_q;
            d_rdata     = rsp_rdata;
          end else begin
            if_rsp_valid = 1'b1;
            if_rsp_err   = fault_q;
            if_rdata     = rsp_rdata;
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: behavioural RAM device plus transaction-level reference memory.
// Compile with MEM_ARB_RR_EN defined to check the round-robin build.
module tb_mem_port_arbiter;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk;
  logic          reset;
  logic          if_req_valid;
  logic          if_req_ready;
  logic [31:0]   if_addr;
  logic          if_rsp_valid;
  logic          if_rsp_err;
  logic [31:0]   if_rdata;
  logic          d_req_valid;
  logic          d_req_ready;
  logic          d_we;
  logic [3:0]    d_wstrb;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_rsp_valid;
  logic          d_rsp_err;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_err   (if_rsp_err),
    .if_rdata     (if_rdata),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_we         (d_we),
    .d_wstrb      (d_wstrb),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_err    (d_rsp_err),
    .d_rdata      (d_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    return (v * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // RAM device driven only by the DUT's mem_* pins.
  logic [31:0] ram_dev [DEPTH];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram_dev[i] <= init_word(i);
      ram_init  <= 1'b1;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      mem_rdata <= ram_dev[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram_dev[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference contents, updated per completed transaction.
  logic [31:0] ref_mem [DEPTH];

  function automatic logic ref_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0;
    if_addr      = 32'h0;
    d_req_valid  = 1'b0;
    d_we         = 1'b0;
    d_wstrb      = 4'h0;
    d_addr       = 32'h0;
    d_wdata      = 32'h0;
  endtask

  // One isolated transaction from an idle arbiter: request cycle, then response cycle.
  task automatic do_txn(input string tag, input logic is_d, input logic we,
                        input logic [3:0] strb, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic        flt;
    logic        st;
    logic [7:0]  widx;
    logic [31:0] exp_rd;
    logic [31:0] w;
    flt    = ref_fault(addr);
    st     = is_d & we;
    widx   = addr[9:2];
    exp_rd = (flt || st) ? 32'h0 : ref_mem[widx];
    @(posedge clk); #1;
    if (is_d) begin
      d_req_valid = 1'b1; d_we = we; d_wstrb = strb; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    @(negedge clk);
    chk({tag, ".if_ready"}, 32'(if_req_ready), 32'(!is_d));
    chk({tag, ".d_ready"},  32'(d_req_ready),  32'(is_d));
    chk({tag, ".mem_en"},   32'(mem_en),       32'(!flt));
    chk({tag, ".mem_we"},   32'(mem_we),       (flt || !st) ? 32'h0 : 32'(strb));
    if (!flt) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(widx));
    if (!flt && st) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk({tag, ".if_rsp_valid"}, 32'(if_rsp_valid), 32'(!is_d));
    chk({tag, ".d_rsp_valid"},  32'(d_rsp_valid),  32'(is_d));
    chk({tag, ".rsp_err"},      32'(is_d ? d_rsp_err : if_rsp_err), 32'(flt));
    chk({tag, ".rdata"},        is_d ? d_rdata : if_rdata, exp_rd);
    chk({tag, ".acc_mem_en"},   32'(mem_en), 32'h0);
    if (st && !flt) begin
      w = ref_mem[widx];
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[widx] = w;
    end
  endtask

  logic [31:0] rnd_addr;
  logic [31:0] old_word;
  logic        exp_if_g [6];
  logic        exp_d_g  [6];
  logic        last_if;
  logic        last_d;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    idle_inputs();
    reset = 1'b0;

    // Reset: outputs forced to 0 even with both requests pending.
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_addr = 32'h10;
    d_req_valid  = 1'b1; d_addr  = 32'h20; d_we = 1'b1; d_wstrb = 4'hF; d_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.if_ready",  32'(if_req_ready), 32'h0);
    chk("rst.d_ready",   32'(d_req_ready),  32'h0);
    chk("rst.mem_en",    32'(mem_en),       32'h0);
    chk("rst.mem_we",    32'(mem_we),       32'h0);
    chk("rst.mem_addr",  32'(mem_addr),     32'h0);
    chk("rst.mem_wdata", mem_wdata,         32'h0);
    chk("rst.rsp",       32'({if_rsp_valid, d_rsp_valid, if_rsp_err, d_rsp_err}), 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;

    do_txn("fetch10", 1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    old_word = ref_mem[8];
    do_txn("store20", 1'b1, 1'b1, 4'b0010, 32'h0000_0020, 32'h0000_AB00);
    chk("store20.ref", ref_mem[8], {old_word[31:16], 8'hAB, old_word[7:0]});
    do_txn("load20", 1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);

    // Contention: both valid for six cycles, last winner was data.
`ifdef MEM_ARB_RR_EN
    exp_if_g = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_d_g  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_if_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_d_g  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    last_if = 1'b0;
    last_d  = 1'b0;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_addr = 32'h40;
    d_req_valid  = 1'b1; d_addr  = 32'h80; d_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("tie%0d.if_ready", c), 32'(if_req_ready), 32'(exp_if_g[c]));
      chk($sformatf("tie%0d.d_ready", c),  32'(d_req_ready),  32'(exp_d_g[c]));
      chk($sformatf("tie%0d.if_rsp", c),   32'(if_rsp_valid), 32'(last_if));
      chk($sformatf("tie%0d.d_rsp", c),    32'(d_rsp_valid),  32'(last_d));
      if (last_d)  chk($sformatf("tie%0d.d_rdata", c),  d_rdata,  ref_mem[32]);
      if (last_if) chk($sformatf("tie%0d.if_rdata", c), if_rdata, ref_mem[16]);
      last_if = exp_if_g[c];
      last_d  = exp_d_g[c];
      @(posedge clk); #1;
    end
    d_req_valid = 1'b0;
    @(negedge clk);
    chk("tie6.if_ready", 32'(if_req_ready), 32'h1);
    chk("tie6.d_ready",  32'(d_req_ready),  32'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("tie7.if_rsp",   32'(if_rsp_valid), 32'h1);
    chk("tie7.if_rdata", if_rdata, ref_mem[16]);

    do_txn("misalign", 1'b1, 1'b0, 4'h0, 32'h0000_0402, 32'h0);
    do_txn("oor",      1'b1, 1'b0, 4'h0, 32'h0000_0400, 32'h0);

    // Reset during the response cycle of a load drops the response.
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    @(negedge clk);
    chk("rstmid.d_ready", 32'(d_req_ready), 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    chk("rstmid.d_rsp",    32'(d_rsp_valid), 32'h0);
    chk("rstmid.d_rdata",  d_rdata,          32'h0);
    chk("rstmid.if_ready", 32'(if_req_ready), 32'h0);
    chk("rstmid.mem_en",   32'(mem_en),       32'h0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.after_rsp", 32'({if_rsp_valid, d_rsp_valid}), 32'h0);
    do_txn("post_rst_fetch", 1'b0, 1'b0, 4'h0, 32'h0000_0044, 32'h0);

    // Random isolated transactions against the reference memory.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        0:       rnd_addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        1:       rnd_addr = {$urandom, 2'b00} | 32'h0000_0400;
        default: rnd_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      if ($urandom_range(0, 1) == 1)
        do_txn($sformatf("rnd%0d", t), 1'b1, 1'($urandom_range(0, 1)),
               4'($urandom), rnd_addr, $urandom);
      else
        do_txn($sformatf("rnd%0d", t), 1'b0, 1'b0, 4'h0, rnd_addr, 32'h0);
    end

    // Every word read back through fetches must match the reference.
    for (int i = 0; i < 8; i++)
      do_txn($sformatf("sweep%0d", i), 1'b0, 1'b0, 4'h0, 32'(i * 128), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
